// File: rtl/img_window_collector.sv
// rtl/img_window_collector.sv - assembles 3x3 window read data into a handshaked window register
module img_window_collector #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [ADDR_W-1:0]     addr_in,
    input  logic                  tap_start,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [9*DATA_W-1:0]   win_data,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic                  seq_err,
    output logic                  overrun,
    output logic [15:0]           win_count
);

    typedef enum logic {WAIT_START, COLLECT} state_t;

    typedef struct packed {
        logic       vld;
        logic       bad;
        logic       start;
        logic [3:0] idx;
    } tag_t;

    state_t                    state_q, state_d;
    logic [3:0]                nxt_idx_q, nxt_idx_d;
    logic [8:0][DATA_W-1:0]    asm_q, asm_d;
    logic [9*DATA_W-1:0]       win_data_q, win_data_d;
    logic                      win_valid_q, win_valid_d;
    logic                      seq_err_q, seq_err_d;
    logic                      overrun_q, overrun_d;
    logic [15:0]               win_count_q, win_count_d;
    tag_t                      pipe_q [RD_LAT];
    tag_t                      pipe_d [RD_LAT];
    tag_t                      tag;
    logic [3:0]                dec_idx;
    logic                      dec_bad;
    logic                      complete;

    always_comb begin
        dec_idx = 4'd0;
        dec_bad = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (addr_in == ADDR_W'((k / 3) * IMG_W + (k % 3))) begin
                dec_idx = 4'(k);
                dec_bad = 1'b0;
            end
        end
    end

    // Tag travels alongside the read so it lines up with mem_rdata RD_LAT cycles later.
    always_comb begin
        pipe_d[0] = {en, dec_bad, tap_start, dec_idx};
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign tag = pipe_q[RD_LAT-1];

    always_comb begin
        state_d     = state_q;
        nxt_idx_d   = nxt_idx_q;
        asm_d       = asm_q;
        win_data_d  = win_data_q;
        win_valid_d = win_valid_q;
        seq_err_d   = seq_err_q;
        overrun_d   = overrun_q;
        win_count_d = win_count_q;
        complete    = 1'b0;
        if (tag.vld) begin
            if (tag.start != (!tag.bad && tag.idx == 4'd0)) begin
                seq_err_d = 1'b1;
            end
            case (state_q)
                WAIT_START: begin
                    if (!tag.bad && tag.idx == 4'd0) begin
                        asm_d[0]  = mem_rdata;
                        nxt_idx_d = 4'd1;
                        state_d   = COLLECT;
                    end
                end
                COLLECT: begin
                    if (!tag.bad && tag.idx == nxt_idx_q) begin
                        asm_d[tag.idx] = mem_rdata;
                        if (nxt_idx_q == 4'd8) begin
                            complete = 1'b1;
                            state_d  = WAIT_START;
                        end else begin
                            nxt_idx_d = nxt_idx_q + 4'd1;
                        end
                    end else if (!tag.bad && tag.idx == 4'd0) begin
                        seq_err_d = 1'b1;
                        asm_d[0]  = mem_rdata;
                        nxt_idx_d = 4'd1;
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = WAIT_START;
                    end
                end
                default: state_d = WAIT_START;
            endcase
        end
        // A new window always wins; the held one is lost only if nobody took it this cycle.
        if (complete) begin
            if (win_valid_q && !win_ready) begin
                overrun_d = 1'b1;
            end
            win_data_d  = asm_d;
            win_valid_d = 1'b1;
            win_count_d = win_count_q + 16'd1;
        end else if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT_START;
            nxt_idx_q   <= 4'd0;
            asm_q       <= '0;
            win_data_q  <= '0;
            win_valid_q <= 1'b0;
            seq_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
            win_count_q <= 16'd0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            nxt_idx_q   <= nxt_idx_d;
            asm_q       <= asm_d;
            win_data_q  <= win_data_d;
            win_valid_q <= win_valid_d;
            seq_err_q   <= seq_err_d;
            overrun_q   <= overrun_d;
            win_count_q <= win_count_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign win_data  = win_data_q;
    assign win_valid = win_valid_q;
    assign seq_err   = seq_err_q;
    assign overrun   = overrun_q;
    assign win_count = win_count_q;

endmodule

// File: tb/tb_img_window_collector.sv
// tb/tb_img_window_collector.sv - random and directed checks of img_window_collector at read latencies 1 and 3
module tb_img_window_collector;

    localparam int IW = 640;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic [10:0] addr_in;
    logic        tap_start;
    logic        win_ready;
    logic [7:0]  rd [2];
    logic [71:0] wd [2];
    logic        wv [2];
    logic        se [2];
    logic        ov [2];
    logic [15:0] wc [2];

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    bit          h_en [5];
    logic [10:0] h_a  [5];
    bit          h_ts [5];
    logic [7:0]  h_d  [5];

    int          m_exp   [2];
    logic [7:0]  m_slot  [2][9];
    logic [71:0] m_data  [2];
    bit          m_valid [2];
    bit          m_seq   [2];
    bit          m_ovr   [2];
    int          m_cnt   [2];
    int          rise    [2];

    img_window_collector #(.DATA_W(8), .IMG_W(IW), .ADDR_W(11), .RD_LAT(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .en(en), .addr_in(addr_in), .tap_start(tap_start),
        .mem_rdata(rd[0]), .win_data(wd[0]), .win_valid(wv[0]), .win_ready(win_ready),
        .seq_err(se[0]), .overrun(ov[0]), .win_count(wc[0]));

    img_window_collector #(.DATA_W(8), .IMG_W(IW), .ADDR_W(11), .RD_LAT(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .en(en), .addr_in(addr_in), .tap_start(tap_start),
        .mem_rdata(rd[1]), .win_data(wd[1]), .win_valid(wv[1]), .win_ready(win_ready),
        .seq_err(se[1]), .overrun(ov[1]), .win_count(wc[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int tap_of(input logic [10:0] a);
        for (int k = 0; k < 9; k++) begin
            if (int'(a) == (k / 3) * IW + (k % 3)) return k;
        end
        return -1;
    endfunction

    function automatic logic [10:0] off(input int k);
        return 11'((k / 3) * IW + (k % 3));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_exp[i] = -1;
            for (int k = 0; k < 9; k++) m_slot[i][k] = 8'h00;
            m_data[i] = '0;
            m_valid[i] = 0;
            m_seq[i] = 0;
            m_ovr[i] = 0;
            m_cnt[i] = 0;
        end
    endtask

    // Applies one clock edge of the window rules to each latency's model.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int L;
            int t;
            bit done;
            logic [7:0] d;
            L = (i == 0) ? 1 : 3;
            done = 0;
            d = h_d[L];
            if (h_en[L]) begin
                t = tap_of(h_a[L]);
                if (h_ts[L] != (t == 0)) m_seq[i] = 1;
                if (m_exp[i] < 0) begin
                    if (t == 0) begin
                        m_slot[i][0] = d;
                        m_exp[i] = 1;
                    end
                end else if (t == m_exp[i]) begin
                    m_slot[i][t] = d;
                    m_exp[i] = m_exp[i] + 1;
                    if (m_exp[i] == 9) begin
                        done = 1;
                        m_exp[i] = -1;
                    end
                end else if (t == 0) begin
                    m_seq[i] = 1;
                    m_slot[i][0] = d;
                    m_exp[i] = 1;
                end else begin
                    m_seq[i] = 1;
                    m_exp[i] = -1;
                end
            end
            if (done) begin
                if (m_valid[i] && !win_ready) m_ovr[i] = 1;
                for (int k = 0; k < 9; k++) m_data[i][k*8 +: 8] = m_slot[i][k];
                m_valid[i] = 1;
                m_cnt[i] = (m_cnt[i] + 1) % 65536;
            end else if (m_valid[i] && win_ready) begin
                m_valid[i] = 0;
            end
        end
    endtask

    task automatic cyc(input bit e, input logic [10:0] a, input bit ts, input logic [7:0] d);
        for (int k = 4; k > 0; k--) begin
            h_en[k] = h_en[k-1];
            h_a[k]  = h_a[k-1];
            h_ts[k] = h_ts[k-1];
            h_d[k]  = h_d[k-1];
        end
        h_en[0] = e;
        h_a[0]  = a;
        h_ts[0] = ts;
        h_d[0]  = d;
        en = e;
        addr_in = a;
        tap_start = ts;
        rd[0] = h_d[1];
        rd[1] = h_d[3];
        @(posedge clk);
        #1;
        if (reset_n) model_edge();
    endtask

    task automatic idle();
        cyc(0, 11'd0, 0, 8'h00);
    endtask

    task automatic tap(input int k, input logic [7:0] base);
        cyc(1, off(k), k == 0, base + 8'(k));
    endtask

    task automatic seq(input logic [7:0] base);
        for (int k = 0; k < 9; k++) tap(k, base);
    endtask

    task automatic idles(input int n);
        for (int j = 0; j < n; j++) idle();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            h_en[k] = 0;
            h_a[k] = '0;
            h_ts[k] = 0;
            h_d[k] = '0;
        end
        #1;
        chk_on = 1;
        idles(2);
        reset_n = 1'b1;
    endtask

    task automatic chk_win(input string nm, input logic [71:0] data, input int cnt, input bit s);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_data%0d", nm, i), wd[i], data);
            chk($sformatf("%s_count%0d", nm, i), 72'(wc[i]), 72'(cnt));
            chk($sformatf("%s_seq_err%0d", nm, i), 72'(se[i]), 72'(s));
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("win_valid%0d", i), 72'(wv[i]), 72'(m_valid[i]));
                chk($sformatf("win_data%0d", i), wd[i], m_data[i]);
                chk($sformatf("seq_err%0d", i), 72'(se[i]), 72'(m_seq[i]));
                chk($sformatf("overrun%0d", i), 72'(ov[i]), 72'(m_ovr[i]));
                chk($sformatf("win_count%0d", i), 72'(wc[i]), 72'(m_cnt[i]));
            end
        end
    end

    initial begin
        int k;
        int r;
        logic [10:0] a;
        en = 0;
        addr_in = '0;
        tap_start = 0;
        win_ready = 1;
        rd[0] = '0;
        rd[1] = '0;
        do_reset();
        chk_win("reset", 72'h0, 0, 0);
        chk("reset_valid", 72'(wv[0] | wv[1] | ov[0] | ov[1]), 72'h0);

        seq(8'h10);
        for (int j = 0; j < 9; j++) tap(j, 8'h10);
        rise[0] = -1;
        rise[1] = -1;
        for (int s = 0; s <= 5; s++) begin
            for (int i = 0; i < 2; i++) if (wv[i] && rise[i] < 0) rise[i] = s;
            idle();
        end
        chk("nominal_rise_lat1", 72'(rise[0]), 72'd1);
        chk("nominal_rise_lat3", 72'(rise[1]), 72'd3);
        chk_win("nominal", 72'h18_17_16_15_14_13_12_11_10, 2, 0);
        chk("nominal_model", m_data[1], 72'h18_17_16_15_14_13_12_11_10);

        do_reset();
        win_ready = 0;
        seq(8'h10);
        seq(8'h40);
        idles(4);
        chk_win("backpressure", 72'h48_47_46_45_44_43_42_41_40, 2, 0);
        chk("bp_overrun", 72'(ov[0] & ov[1] & wv[0] & wv[1]), 72'h1);
        win_ready = 1;
        idle();
        chk("bp_drained", 72'(wv[0] | wv[1]), 72'h0);

        do_reset();
        for (int j = 0; j < 9; j++) begin
            if (j == 4) cyc(1, 11'd700, 0, 8'h24);
            else tap(j, 8'h20);
        end
        seq(8'h30);
        idles(5);
        chk_win("bad_offset", 72'h38_37_36_35_34_33_32_31_30, 1, 1);

        do_reset();
        for (int j = 0; j < 5; j++) tap(j, 8'h50);
        seq(8'h60);
        idles(5);
        chk_win("restart", 72'h68_67_66_65_64_63_62_61_60, 1, 1);

        do_reset();
        seq(8'h10);
        idles(5);
        for (int j = 0; j < 6; j++) tap(j, 8'h70);
        reset_n = 0;
        #1;
        chk_win("midreset", 72'h0, 0, 0);
        do_reset();
        seq(8'h80);
        idles(5);
        chk_win("after_reset", 72'h88_87_86_85_84_83_82_81_80, 1, 0);

        do_reset();
        for (int j = 0; j < 4; j++) tap(j, 8'h90);
        idles(3);
        for (int j = 4; j < 9; j++) tap(j, 8'h90);
        idles(5);
        chk_win("pause", 72'h98_97_96_95_94_93_92_91_90, 1, 0);

        do_reset();
        k = 0;
        for (int n = 0; n < 1500; n++) begin
            win_ready = ($urandom % 100) < 70;
            r = $urandom % 100;
            if (r < 8) begin
                idle();
            end else if (r < 11) begin
                a = ($urandom % 2 == 0) ? 11'($urandom % 2048) : off($urandom % 9);
                cyc(1, a, ($urandom % 4 == 0) ? (a != 11'd0) : (a == 11'd0), 8'($urandom));
            end else begin
                if (r < 13) k = 0;
                cyc(1, off(k), k == 0, 8'($urandom));
                k = (k + 1) % 9;
            end
        end
        idles(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
